// File: rtl/seg_scanner_n_pkg.sv
// -----------------------------------------------------------------------------
// seg_scanner_n_pkg
// Shared types and helpers for the multiplexed 7-segment scanner.
//   seg_t      : one digit's segment pattern, bit7 = DP, 1 = lit
//   seg_drive  : maps a lit-high pattern onto the board's segment polarity
// -----------------------------------------------------------------------------
package seg_scanner_n_pkg;

    localparam int SEG_W = 8;

    typedef logic [SEG_W-1:0] seg_t;

    // Convert a lit-high pattern into pin levels for the given active level.
    function automatic seg_t seg_drive(input seg_t pat, input logic act);
        return act ? pat : ~pat;
    endfunction

endpackage

// File: rtl/seg_scanner_n_clock_divider.sv
// -----------------------------------------------------------------------------
// seg_scanner_n_clock_divider
// Produces a one-cycle tick every DIV clock cycles. With DIV = 1 the tick is
// permanently high, so downstream counters advance on every clock.
// Ports:
//   Clock  in  system clock
//   Reset  in  asynchronous, active-low
//   tick   out one-cycle strobe, period DIV
// -----------------------------------------------------------------------------
module seg_scanner_n_clock_divider
    import seg_scanner_n_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic Clock,
    input  logic Reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;

    // Free-running modulo-DIV cycle counter.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tick = (cnt_r == CNT_MAX);

endmodule

// File: rtl/seg_scanner_n.sv
// -----------------------------------------------------------------------------
// seg_scanner_n
// Time-multiplexed driver for an NDIG-digit 7-segment + DP display. One digit
// is driven per slot of 2**BW ticks; the first BLANK ticks of a slot and every
// tick at or beyond 'bright' are dark. New digit data is captured into a shadow
// buffer and only copied into the displayed (active) buffer at a frame
// boundary, so a single frame never mixes old and new digits.
// Ports:
//   Clock       in   system clock
//   Reset       in   asynchronous, active-low
//   digits      in   8*NDIG segment patterns, digit k = digits[8k+7:8k]
//   load        in   1-cycle strobe, capture digits
//   enable      in   per-digit enable (slot kept, but dark when 0)
//   bright      in   end of lit window within a slot
//   SD          out  digit selects, registered, active level SD_ACT
//   SEG         out  segment lines, registered, active level SEG_ACT
//   frame_done  out  1-cycle pulse, first cycle of each new frame
//   pending     out  shadow holds data not yet displayed
// -----------------------------------------------------------------------------
module seg_scanner_n
    import seg_scanner_n_pkg::*;
#(
    parameter int   NDIG    = 4,
    parameter int   DIV     = 50000,
    parameter int   BW      = 4,
    parameter int   BLANK   = 1,
    parameter logic SD_ACT  = 1'b1,
    parameter logic SEG_ACT = 1'b1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [8*NDIG-1:0]   digits,
    input  logic                load,
    input  logic [NDIG-1:0]     enable,
    input  logic [BW-1:0]       bright,
    output logic [NDIG-1:0]     SD,
    output logic [SEG_W-1:0]    SEG,
    output logic                frame_done,
    output logic                pending
);

    localparam int            IDXW     = $clog2(NDIG);
    localparam logic [BW-1:0] PH_MAX   = '1;
    localparam logic [BW-1:0] BLANK_V  = BW'(BLANK);
    localparam logic [IDXW-1:0] IDX_MAX = IDXW'(NDIG - 1);

    logic                       tick_s;
    logic [BW-1:0]              phase_r;
    logic [IDXW-1:0]            idx_r;
    logic [NDIG-1:0][SEG_W-1:0] shadow_r;
    logic [NDIG-1:0][SEG_W-1:0] active_r;
    logic                       pending_r;
    logic [NDIG-1:0]            sd_r;
    seg_t                       seg_r;
    logic                       frame_done_r;

    logic                       phase_wrap_s;
    logic                       boundary_s;
    logic                       lit_s;
    logic [NDIG-1:0]            sd_onehot_s;
    logic [NDIG-1:0]            sd_nxt_s;
    seg_t                       seg_nxt_s;

    seg_scanner_n_clock_divider #(
        .DIV (DIV)
    ) u_div (
        .Clock (Clock),
        .Reset (Reset),
        .tick  (tick_s)
    );

    assign phase_wrap_s = tick_s && (phase_r == PH_MAX);
    // A frame ends when the last digit's last phase wraps.
    assign boundary_s   = phase_wrap_s && (idx_r == IDX_MAX);

    // Unsigned compare; phase PH_MAX can never be below a BW-bit 'bright',
    // so every slot ends with at least one dark tick.
    assign lit_s        = enable[idx_r] && (phase_r >= BLANK_V) && (phase_r < bright);
    assign sd_onehot_s  = NDIG'(1) << idx_r;

    // Phase and digit-index counters, advancing only on ticks.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            phase_r <= '0;
            idx_r   <= '0;
        end else if (tick_s) begin
            phase_r <= phase_r + BW'(1);
            if (phase_r == PH_MAX) begin
                // NDIG need not be a power of two, so wrap explicitly.
                idx_r <= (idx_r == IDX_MAX) ? '0 : idx_r + IDXW'(1);
            end
        end
    end

    // Shadow/active double buffer with frame-synchronous hand-over.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            shadow_r  <= '0;
            active_r  <= '0;
            pending_r <= 1'b0;
        end else if (boundary_s) begin
            // A load coinciding with the boundary goes straight to the display.
            if (load) begin
                active_r <= digits;
            end else if (pending_r) begin
                active_r <= shadow_r;
            end
            pending_r <= 1'b0;
        end else if (load) begin
            shadow_r  <= digits;
            pending_r <= 1'b1;
        end
    end

    // Next output levels for the current index/phase.
    always_comb begin
        sd_nxt_s  = {NDIG{~SD_ACT}};
        seg_nxt_s = {SEG_W{~SEG_ACT}};
        if (lit_s) begin
            sd_nxt_s  = SD_ACT ? sd_onehot_s : ~sd_onehot_s;
            seg_nxt_s = seg_drive(active_r[idx_r], SEG_ACT);
        end else begin
            sd_nxt_s  = {NDIG{~SD_ACT}};
            seg_nxt_s = {SEG_W{~SEG_ACT}};
        end
    end

    // Registered pin drivers and frame strobe.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sd_r         <= {NDIG{~SD_ACT}};
            seg_r        <= {SEG_W{~SEG_ACT}};
            frame_done_r <= 1'b0;
        end else begin
            sd_r         <= sd_nxt_s;
            seg_r        <= seg_nxt_s;
            frame_done_r <= boundary_s;
        end
    end

    assign SD         = sd_r;
    assign SEG        = seg_r;
    assign frame_done = frame_done_r;
    assign pending    = pending_r;

endmodule
